// File: rtl/div_fx_stream.sv
// Iterative signed/unsigned fixed-point divider with valid/ready on both sides, 1 quotient bit per cycle.
// Result valid WIDTH+FBITS+2 edges after accept (divide-by-zero: right after the accept edge); HOLD stalls input.
module div_fx_stream #(
  parameter int WIDTH = 16,
  parameter int FBITS = 8,
  parameter int TAGW  = 4,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  input  logic             in_rnd,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_dbz,
  output logic             out_ovf
);

  localparam int ITER = WIDTH + FBITS;
  localparam int QW   = ITER + 1;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0]    LAST  = CW'(ITER - 1);
  localparam logic [QW-1:0]    L_UNS = {{(QW-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [QW-1:0]    L_POS = L_UNS >> 1;
  localparam logic [QW-1:0]    L_NEG = L_POS + QW'(1);
  localparam logic [WIDTH-1:0] V_UMAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] V_SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] V_SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ROUND, S_SIGN, S_HOLD} state_t;

  state_t           r_state, w_next;
  logic [ITER-1:0]  r_num;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_acc;
  logic [QW-1:0]    r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_neg, r_sgn, r_rnd;
  logic [TAGW-1:0]  r_tag;

  logic             w_accept, w_ge, w_ovf;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_rem, w_qlo, w_res, w_satv;
  logic [WIDTH:0]   w_shift, w_sub;
  logic [QW-1:0]    w_lim;

  // 0x8000-style minimum negates to itself, which is the exact unsigned magnitude
  assign w_mag_a  = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign w_mag_b  = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
  assign w_accept = in_valid && in_ready;

  // After ITER shifts r_num is all zeros, so the same step yields the guard bit in ROUND
  assign w_shift = {r_acc, r_num[ITER-1]};
  assign w_sub   = w_shift - {1'b0, r_div};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_rem   = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];

  assign w_lim  = !r_sgn ? L_UNS : (r_neg ? L_NEG : L_POS);
  assign w_ovf  = (r_q > w_lim);
  assign w_qlo  = r_q[WIDTH-1:0];
  assign w_res  = r_neg ? -w_qlo : w_qlo;
  assign w_satv = (SAT != 0) ? (!r_sgn ? V_UMAX : (r_neg ? V_SMIN : V_SMAX)) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_CALC:  if (r_cnt == LAST) w_next = S_ROUND;
      S_ROUND: w_next = S_SIGN;
      S_SIGN:  w_next = S_HOLD;
      S_HOLD: begin
        in_ready = out_ready;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (rst) in_ready = 1'b0;
    if (in_valid && in_ready) w_next = (in_b == '0) ? S_HOLD : S_CALC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num     <= '0;
      r_div     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_sgn     <= 1'b0;
      r_rnd     <= 1'b0;
      r_tag     <= '0;
      out_valid <= 1'b0;
      out_val   <= '0;
      out_tag   <= '0;
      out_dbz   <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_num <= ITER'(w_mag_a) << FBITS;
      r_div <= w_mag_b;
      r_acc <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_neg <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      r_sgn <= in_signed;
      r_rnd <= in_rnd;
      r_tag <= in_tag;
      if (in_b == '0) begin
        out_valid <= 1'b1;
        out_val   <= '0;
        out_tag   <= in_tag;
        out_dbz   <= 1'b1;
        out_ovf   <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end else begin
      case (r_state)
        S_CALC: begin
          r_num <= r_num << 1;
          r_acc <= w_rem;
          r_q   <= {r_q[QW-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        S_ROUND: begin
          // half-even: round up above half, or at exactly half when q is odd
          if (r_rnd && w_ge && (r_q[0] || (w_rem != '0))) r_q <= r_q + QW'(1);
        end
        S_SIGN: begin
          out_valid <= 1'b1;
          out_dbz   <= 1'b0;
          out_ovf   <= w_ovf;
          out_val   <= w_ovf ? w_satv : w_res;
          out_tag   <= r_tag;
        end
        S_HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_fx_stream.sv
// Scoreboard bench for div_fx_stream: arithmetic reference model, SAT=1 and SAT=0 instances in lockstep.
module tb_div_fx_stream;

  typedef struct {
    logic [15:0] val;
    logic [15:0] val0;
    logic [3:0]  tag;
    logic        dbz;
    logic        ovf;
    int          acc_cyc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_signed = 1'b0, in_rnd = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_dbz, out_ovf;
  logic [15:0] out_val;
  logic [3:0]  out_tag;
  logic        in_ready0, out_valid0, out_dbz0, out_ovf0;
  logic [15:0] out_val0;
  logic [3:0]  out_tag0;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sb[$];

  div_fx_stream #(.WIDTH(16), .FBITS(8), .TAGW(4), .SAT(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_rnd(in_rnd), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val), .out_tag(out_tag),
    .out_dbz(out_dbz), .out_ovf(out_ovf));

  div_fx_stream #(.WIDTH(16), .FBITS(8), .TAGW(4), .SAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_rnd(in_rnd), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready), .out_val(out_val0), .out_tag(out_tag0),
    .out_dbz(out_dbz0), .out_ovf(out_ovf0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Q8.8 reference: exact integer quotient/remainder, half-even decided from 2*rem vs divisor
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic r, input logic [3:0] t);
    exp_t   e;
    longint ma, mb, num, q, rem, lim;
    logic   neg;
    e.tag = t; e.dbz = 1'b0; e.ovf = 1'b0; e.lat = 26; e.acc_cyc = 0;
    if (b == 16'h0) begin
      e.val = '0; e.val0 = '0; e.dbz = 1'b1; e.lat = 0;
      return e;
    end
    ma  = (s && a[15]) ? 65536 - longint'(a) : longint'(a);
    mb  = (s && b[15]) ? 65536 - longint'(b) : longint'(b);
    neg = s && (a[15] ^ b[15]);
    num = ma * 256;
    q   = num / mb;
    rem = num % mb;
    if (r && ((2 * rem > mb) || ((2 * rem == mb) && (q % 2 == 1)))) q = q + 1;
    lim = !s ? 65535 : (neg ? 32768 : 32767);
    if (q > lim) begin
      e.ovf  = 1'b1;
      e.val  = !s ? 16'hFFFF : (neg ? 16'h8000 : 16'h7FFF);
      e.val0 = 16'h0000;
    end else begin
      e.val  = neg ? 16'(-q) : 16'(q);
      e.val0 = e.val;
    end
    return e;
  endfunction

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic r, input logic [3:0] t);
    exp_t e;
    e = model(a, b, s, r, t);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic r, input logic [3:0] t);
    in_a = a; in_b = b; in_signed = s; in_rnd = r; in_tag = t; in_valid = 1'b1;
  endtask

  // Present a request, wait (bounded) for acceptance, then scramble the inputs
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic r, input logic [3:0] t);
    int n;
    n = 0;
    @(negedge clk);
    drive(a, b, s, r, t);
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (in_ready) begin
      push_exp(a, b, s, r, t);
      @(posedge clk);
    end else begin
      chk("accept_timeout", 32'd0, 32'd1);
    end
    #1;
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_tag = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin : mon
    bit   fresh;
    exp_t e;
    fresh = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        fresh = 1'b1;
        continue;
      end
      if (out_valid && fresh && sb.size() > 0) begin
        chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
        fresh = 1'b0;
      end
      if (!out_valid) begin
        fresh = 1'b1;
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("val", out_val, e.val);
          chk("tag", out_tag, e.tag);
          chk("dbz", out_dbz, e.dbz);
          chk("ovf", out_ovf, e.ovf);
          chk("nosat_vld", out_valid0, 1'b1);
          chk("nosat_val", out_val0, e.val0);
          chk("nosat_ovf", out_ovf0, e.ovf);
        end
        fresh = 1'b1;
      end
    end
  end

  initial begin : stim
    logic [15:0] ra, rb;
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_val", out_val, 16'h0);
    chk("rst_tag", out_tag, 4'h0);
    chk("rst_flags", {out_dbz, out_ovf}, 2'b00);
    chk("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);

    // 3.0 / 2.0 = 1.5
    send(16'h0300, 16'h0200, 1'b1, 1'b1, 4'h5);
    drain();
    // thirds: 0x0055, -1/3 rounds to 0xFFAB, truncation toward zero also 0xFFAB
    send(16'h0100, 16'h0300, 1'b1, 1'b1, 4'h1);
    send(16'hFF00, 16'h0300, 1'b1, 1'b1, 4'h2);
    send(16'hFF00, 16'h0300, 1'b1, 1'b0, 4'h3);
    // exact ties against divisor 2.0
    send(16'h0001, 16'h0200, 1'b1, 1'b1, 4'h4);
    send(16'h0001, 16'h0200, 1'b1, 1'b0, 4'h5);
    send(16'h0003, 16'h0200, 1'b1, 1'b1, 4'h6);
    send(16'h0003, 16'h0200, 1'b1, 1'b0, 4'h7);
    send(16'h0005, 16'h0200, 1'b1, 1'b1, 4'h8);
    // range limits
    send(16'h8000, 16'h0100, 1'b1, 1'b1, 4'h9);
    send(16'h8000, 16'hFF00, 1'b1, 1'b1, 4'hA);
    send(16'h7F00, 16'h0080, 1'b1, 1'b0, 4'hB);
    send(16'hFF00, 16'h0200, 1'b0, 1'b1, 4'hC);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'hD);
    // divide by zero, then a normal request
    send(16'h1234, 16'h0000, 1'b1, 1'b1, 4'hE);
    send(16'h0300, 16'h0200, 1'b1, 1'b0, 4'hF);
    drain();

    // backpressure: hold result for 5 cycles, then retire and accept on one edge
    @(negedge clk);
    out_ready = 1'b0;
    send(16'h0600, 16'h0200, 1'b1, 1'b1, 4'h3);
    for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_val", out_val, sb[0].val);
      chk("stall_tag", out_tag, sb[0].tag);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    drive(16'h0900, 16'h0300, 1'b1, 1'b1, 4'h6);
    #1;
    chk("same_edge_in_ready", in_ready, 1'b1);
    chk("same_edge_out_valid", out_valid, 1'b1);
    push_exp(16'h0900, 16'h0300, 1'b1, 1'b1, 4'h6);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("valid_drop_for_calc", out_valid, 1'b0);
    drain();

    // reset in the middle of a calculation
    send(16'h0500, 16'h0300, 1'b1, 1'b1, 4'h2);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", in_ready, 1'b1);
    repeat (40) @(negedge clk);
    chk("postrst_quiet", out_valid, 1'b0);
    send(16'h0300, 16'h0200, 1'b1, 1'b1, 4'h5);
    drain();

    // random mix, occasional zero divisors
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      send(ra, rb, 1'($urandom), 1'($urandom), 4'($urandom));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
